// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: byte input and event output bundle of the scan-code decoder.
//   din_new/din          : received byte strobe and value
//   evt_valid/evt_ready  : event FIFO head handshake
//   evt_code/evt_break   : head event payload {extended, code} and release flag
//   key_down             : pressed-key bitmap indexed by {extended, code}
//   seq_error/overflow   : one-cycle status pulses
// master = byte source / event consumer, slave = decoder.
interface ps2_scancode_decoder_if;
   logic         din_new;
   logic [7:0]   din;
   logic         evt_valid;
   logic         evt_ready;
   logic [8:0]   evt_code;
   logic         evt_break;
   logic [511:0] key_down;
   logic         seq_error;
   logic         overflow;

   modport master (
      output din_new, din, evt_ready,
      input  evt_valid, evt_code, evt_break, key_down, seq_error, overflow
   );

   modport slave (
      input  din_new, din, evt_ready,
      output evt_valid, evt_code, evt_break, key_down, seq_error, overflow
   );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: PS/2 Set-2 scan-code decoder with E0/F0/E1-Pause handling,
// optional typematic repeat filter, pressed-key bitmap and a FWFT event FIFO.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : ps2_scancode_decoder_if.slave (byte input, event output, status)
module ps2_scancode_decoder #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned REPEAT_FILTER  = 1,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter logic [8:0]  PAUSE_CODE     = 9'h1E1
) (
   input logic                    clk,
   input logic                    resetN,
   ps2_scancode_decoder_if.slave  bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_EXT, S_REL, S_EXT_REL, S_PAUSE} state_e;

   typedef struct packed {
      logic       brk;
      logic [8:0] code;
   } evt_t;

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [CW-1:0]   tmo_q;
   logic            ev_v_q, ev_v_d;
   logic            ev_pause_q, ev_pause_d;
   evt_t            ev_q, ev_d;
   logic            seq_err_q, seq_err_d;
   logic [511:0]    key_down_q;
   logic [PW-1:0]   wr_q, rd_q;
   evt_t            mem_q [FIFO_DEPTH];

   logic            is_norm;
   logic            empty, full, pop, filtered, push_req, push_ok;

   // Expected bytes 1..7 of the E1 Pause sequence.
   function automatic logic [7:0] pause_byte(input logic [2:0] i);
      case (i)
         3'd1:    pause_byte = 8'h14;
         3'd2:    pause_byte = 8'h77;
         3'd3:    pause_byte = 8'hE1;
         3'd4:    pause_byte = 8'hF0;
         3'd5:    pause_byte = 8'h14;
         3'd6:    pause_byte = 8'hF0;
         3'd7:    pause_byte = 8'h77;
         default: pause_byte = 8'h00;
      endcase
   endfunction

   assign is_norm = (bus.din != 8'h00) && (bus.din <= 8'h83);

   // Decoder state register; the decoded event is held one cycle before the FIFO.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= S_IDLE;
         idx_q      <= 3'd0;
         ev_v_q     <= 1'b0;
         ev_pause_q <= 1'b0;
         ev_q       <= '0;
         seq_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ev_v_q     <= ev_v_d;
         ev_pause_q <= ev_pause_d;
         ev_q       <= ev_d;
         seq_err_q  <= seq_err_d;
      end
   end

   // Next-state decode of one byte, or inter-byte timeout when no byte arrives.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ev_v_d     = 1'b0;
      ev_pause_d = 1'b0;
      ev_d       = '0;
      seq_err_d  = 1'b0;
      if (bus.din_new) begin
         case (state_q)
            S_IDLE: begin
               if (is_norm) begin
                  ev_v_d = 1'b1;
                  ev_d   = '{brk: 1'b0, code: {1'b0, bus.din}};
               end else if (bus.din == 8'hE0) begin
                  state_d = S_EXT;
               end else if (bus.din == 8'hF0) begin
                  state_d = S_REL;
               end else if (bus.din == 8'hE1) begin
                  state_d = S_PAUSE;
                  idx_d   = 3'd1;
               end
            end
            S_EXT: begin
               state_d = S_IDLE;
               if (is_norm) begin
                  ev_v_d = 1'b1;
                  ev_d   = '{brk: 1'b0, code: {1'b1, bus.din}};
               end else if (bus.din == 8'hF0) begin
                  state_d = S_EXT_REL;
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            S_REL, S_EXT_REL: begin
               state_d = S_IDLE;
               if (is_norm) begin
                  ev_v_d = 1'b1;
                  ev_d   = '{brk: 1'b1, code: {state_q == S_EXT_REL, bus.din}};
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            S_PAUSE: begin
               if (bus.din == pause_byte(idx_q)) begin
                  if (idx_q == 3'd7) begin
                     state_d    = S_IDLE;
                     idx_d      = 3'd0;
                     ev_v_d     = 1'b1;
                     ev_pause_d = 1'b1;
                     ev_d       = '{brk: 1'b0, code: PAUSE_CODE};
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  state_d   = S_IDLE;
                  idx_d     = 3'd0;
                  seq_err_d = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = 3'd0;
            end
         endcase
      end else if ((state_q != S_IDLE) && (tmo_q == CW'(TIMEOUT_CYCLES))) begin
         state_d   = S_IDLE;
         idx_d     = 3'd0;
         seq_err_d = 1'b1;
      end
   end

   // Inter-byte idle counter; saturates, held at zero in IDLE.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         tmo_q <= '0;
      end else if (bus.din_new || (state_q == S_IDLE)) begin
         tmo_q <= '0;
      end else if (tmo_q != CW'(TIMEOUT_CYCLES)) begin
         tmo_q <= tmo_q + CW'(1);
      end
   end

   // Repeat filter looks at the bitmap before this event updates it.
   assign filtered = (REPEAT_FILTER != 0) && !ev_q.brk && !ev_pause_q && key_down_q[ev_q.code];
   assign push_req = ev_v_q && !filtered;
   assign empty    = (wr_q == rd_q);
   assign full     = ((wr_q ^ rd_q) == PW'(FIFO_DEPTH));
   assign pop      = !empty && bus.evt_ready;
   assign push_ok  = push_req && (!full || pop);

   // Pressed-key bitmap, updated regardless of FIFO space.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         key_down_q <= '0;
      end else if (ev_v_q && !ev_pause_q) begin
         key_down_q[ev_q.code] <= !ev_q.brk;
      end
   end

   // FIFO pointers; one extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + PW'(1);
         if (pop)     rd_q <= rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= ev_q;
   end

   assign bus.evt_valid = !empty;
   assign bus.evt_code  = empty ? 9'h000 : mem_q[rd_q[AW-1:0]].code;
   assign bus.evt_break = empty ? 1'b0   : mem_q[rd_q[AW-1:0]].brk;
   assign bus.key_down  = key_down_q;
   assign bus.seq_error = seq_err_q;
   assign bus.overflow  = push_req && full && !pop;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed bench with an event scoreboard for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;

   localparam int unsigned TMO = 20;

   logic clk;
   logic resetN;
   int   vectors;
   int   miscompares;
   int   nf_mk;
   int   nf_brk;
   logic [9:0] sb [$];

   ps2_scancode_decoder_if bif ();
   ps2_scancode_decoder_if bif_nf ();

   ps2_scancode_decoder #(
      .FIFO_DEPTH(4), .REPEAT_FILTER(1), .TIMEOUT_CYCLES(TMO), .PAUSE_CODE(9'h1E1)
   ) dut (
      .clk(clk), .resetN(resetN), .bus(bif)
   );

   ps2_scancode_decoder #(
      .FIFO_DEPTH(4), .REPEAT_FILTER(0), .TIMEOUT_CYCLES(TMO), .PAUSE_CODE(9'h1E1)
   ) dut_nf (
      .clk(clk), .resetN(resetN), .bus(bif_nf)
   );

   assign bif_nf.din_new   = bif.din_new;
   assign bif_nf.din       = bif.din;
   assign bif_nf.evt_ready = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bif.din     = b;
      bif.din_new = 1'b1;
      tick();
      bif.din_new = 1'b0;
   endtask

   task automatic expect_evt(input logic brk, input logic [8:0] code);
      sb.push_back({brk, code});
   endtask

   // Scoreboard: compare every accepted head event against the expected queue.
   always @(negedge clk) begin
      if (resetN && bif.evt_valid && bif.evt_ready) begin
         if (sb.size() == 0) begin
            chk("evt_extra", 32'(sb.size()), 32'd1);
         end else begin
            logic [9:0] e;
            e = sb.pop_front();
            chk("evt", 32'({bif.evt_break, bif.evt_code}), 32'(e));
         end
      end
   end

   // Unfiltered instance: count makes and breaks it delivers.
   always @(negedge clk) begin
      if (resetN && bif_nf.evt_valid) begin
         if (bif_nf.evt_break) nf_brk++;
         else                  nf_mk++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int mk0, bk0, lat;
      vectors = 0; miscompares = 0; nf_mk = 0; nf_brk = 0;
      resetN = 1'b0; bif.din_new = 1'b0; bif.din = 8'h00; bif.evt_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(bif.evt_valid), 32'd0);
      chk("rst_code", 32'(bif.evt_code), 32'd0);
      chk("rst_break", 32'(bif.evt_break), 32'd0);
      chk("rst_keys_zero", 32'(bif.key_down == '0), 32'd1);
      chk("rst_seq_error", 32'(bif.seq_error), 32'd0);
      chk("rst_overflow", 32'(bif.overflow), 32'd0);
      resetN = 1'b1;
      tick();
      bif.evt_ready = 1'b1;

      // Plain make then break, with 2-cycle latency.
      expect_evt(1'b0, 9'h01C);
      send(8'h1C);
      chk("lat_n1_valid", 32'(bif.evt_valid), 32'd0);
      tick();
      chk("lat_n2_valid", 32'(bif.evt_valid), 32'd1);
      chk("key01C_set", 32'(bif.key_down[9'h01C]), 32'd1);
      expect_evt(1'b1, 9'h01C);
      send(8'hF0); send(8'h1C);
      tick();
      chk("key01C_clr", 32'(bif.key_down[9'h01C]), 32'd0);

      // Extended key while 1C is held.
      expect_evt(1'b0, 9'h01C); send(8'h1C);
      expect_evt(1'b0, 9'h175); send(8'hE0); send(8'h75);
      tick();
      chk("key175_set", 32'(bif.key_down[9'h175]), 32'd1);
      chk("key01C_held", 32'(bif.key_down[9'h01C]), 32'd1);
      expect_evt(1'b1, 9'h175); send(8'hE0); send(8'hF0); send(8'h75);
      tick();
      chk("key175_clr", 32'(bif.key_down[9'h175]), 32'd0);
      chk("key01C_still", 32'(bif.key_down[9'h01C]), 32'd1);
      expect_evt(1'b1, 9'h01C); send(8'hF0); send(8'h1C);
      repeat (2) tick();

      // Typematic repeat filter versus unfiltered instance.
      mk0 = nf_mk; bk0 = nf_brk;
      expect_evt(1'b0, 9'h01C);
      send(8'h1C); send(8'h1C); send(8'h1C);
      expect_evt(1'b1, 9'h01C);
      send(8'hF0); send(8'h1C);
      repeat (4) tick();
      chk("rep_sb_drained", 32'(sb.size()), 32'd0);
      chk("nf_makes", 32'(nf_mk - mk0), 32'd3);
      chk("nf_breaks", 32'(nf_brk - bk0), 32'd1);

      // Pause sequence, then an aborted one.
      expect_evt(1'b0, 9'h1E1);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      repeat (3) tick();
      chk("pause_sb_drained", 32'(sb.size()), 32'd0);
      chk("pause_no_key", 32'(bif.key_down[9'h1E1]), 32'd0);
      send(8'hE1); send(8'h14); send(8'h99);
      chk("pause_err_pulse", 32'(bif.seq_error), 32'd1);
      tick();
      chk("pause_err_end", 32'(bif.seq_error), 32'd0);
      expect_evt(1'b0, 9'h01C); send(8'h1C);
      expect_evt(1'b1, 9'h01C); send(8'hF0); send(8'h1C);
      repeat (3) tick();
      chk("abort_sb_drained", 32'(sb.size()), 32'd0);

      // FIFO fill, overflow, then push while full with a pop.
      bif.evt_ready = 1'b0;
      expect_evt(1'b0, 9'h015); send(8'h15);
      expect_evt(1'b0, 9'h01D); send(8'h1D);
      expect_evt(1'b0, 9'h024); send(8'h24);
      expect_evt(1'b0, 9'h02D); send(8'h2D);
      send(8'h2C);
      chk("ovf_pulse", 32'(bif.overflow), 32'd1);
      chk("full_head_code", 32'(bif.evt_code), 32'h015);
      tick();
      chk("ovf_end", 32'(bif.overflow), 32'd0);
      chk("hold_valid", 32'(bif.evt_valid), 32'd1);
      chk("hold_code", 32'(bif.evt_code), 32'h015);
      chk("hold_break", 32'(bif.evt_break), 32'd0);
      expect_evt(1'b0, 9'h035); send(8'h35);
      bif.evt_ready = 1'b1;
      #1;
      chk("full_pop_no_ovf", 32'(bif.overflow), 32'd0);
      repeat (8) tick();
      chk("fifo_sb_drained", 32'(sb.size()), 32'd0);

      // Inter-byte timeout after E0.
      send(8'hE0);
      lat = -1;
      for (int j = 1; j <= 60; j++) begin
         if (bif.seq_error) begin
            lat = j;
            break;
         end
         tick();
      end
      chk("timeout_latency", 32'(lat), 32'(TMO + 2));
      tick();
      chk("timeout_err_end", 32'(bif.seq_error), 32'd0);
      expect_evt(1'b0, 9'h075); send(8'h75);
      expect_evt(1'b1, 9'h075); send(8'hF0); send(8'h75);
      repeat (3) tick();
      chk("timeout_sb_drained", 32'(sb.size()), 32'd0);

      // Reset after F0 discards the pending release.
      expect_evt(1'b0, 9'h01C); send(8'h1C);
      repeat (3) tick();
      chk("pre_rst_key", 32'(bif.key_down[9'h01C]), 32'd1);
      send(8'hF0);
      resetN = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(bif.evt_valid), 32'd0);
      chk("mid_rst_keys", 32'(bif.key_down == '0), 32'd1);
      chk("mid_rst_seq_error", 32'(bif.seq_error), 32'd0);
      chk("mid_rst_overflow", 32'(bif.overflow), 32'd0);
      resetN = 1'b1;
      tick();
      expect_evt(1'b0, 9'h01C); send(8'h1C);
      tick();
      chk("post_rst_make_key", 32'(bif.key_down[9'h01C]), 32'd1);
      repeat (4) tick();
      chk("final_sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
